ps2_key_event_controller: RTL
=============================

// Module: ps2_key_event_controller
// PURPOSE
// - Sequences the byte stream from the PS/2 scan-code receiver into complete key events.
// - Decodes E0 (extended), F0 (break) and E1 (Pause) sequences and tracks Shift/Ctrl/Alt state.
// - Queues events in a small FIFO with a pop handshake for the CPU/MMIO side.
// - Sits between the PS/2 receiver (scanCode/scanCodeReady) and the keyboard MMIO register.
// PARAMETERS
// FIFO_DEPTH      8           event FIFO entries; must be a power of two, >=2
// TIMEOUT_CYCLES  50_000_000  clk cycles a prefix state may wait for its next byte
// PORTS
// clk            in   1    system clock
// rst            in   1    asynchronous, active-low reset
// scanCode       in   8    received byte; valid only while scanCodeReady=1
// scanCodeReady  in   1    one-clk pulse per received byte (clk domain)
// eventData      out  10   FIFO head: [9]=break, [8]=extended, [7:0]=code
// eventValid     out  1    FIFO not empty
// eventRead      in   1    pop head this cycle; ignored when eventValid=0
// fifoCount      out  $clog2(FIFO_DEPTH)+1  entries held (0..FIFO_DEPTH)
// shiftHeld      out  1    left (12) or right (59) Shift is down
// ctrlHeld       out  1    left (14) or right (E0 14) Ctrl is down
// altHeld        out  1    left (11) or right (E0 11) Alt is down
// overflow       out  1    sticky; an event was dropped because the FIFO was full
// overflowClear  in   1    clears overflow; a new drop in the same cycle wins (stays 1)
// BEHAVIOUR
// - Reset: all outputs 0, FIFO empty, FSM IDLE, counters 0, modifier flags 0. Reset mid-sequence discards the partial sequence.
// - FSM (advances only on scanCodeReady, except for timeout):
//   IDLE:   E0->EXT; F0->BRK; E1->SKIP (skipCnt=7); other->emit {0,0,code}
//   EXT:    F0->EXTBRK; E0->stay; other->emit {0,1,code}, ->IDLE
//   BRK:    F0->stay; E0->EXTBRK; other->emit {1,0,code}, ->IDLE
//   EXTBRK: E0/F0->stay; other->emit {1,1,code}, ->IDLE
//   SKIP:   each byte decrements skipCnt; on the byte where skipCnt==1, emit {0,1,E1}, ->IDLE
// - Timeout: in EXT/BRK/EXTBRK/SKIP, a cycle counter clears on every scanCodeReady and increments
//   otherwise. At TIMEOUT_CYCLES-1 the FSM returns to IDLE with no emit.
// - Modifiers update in the emit cycle and are visible next clk. Make sets the flag, break clears it.
//   Extended 12/59 (fake shift) do not affect shiftHeld; all emitted events still enter the FIFO.
// - FIFO: registered memory with wrapping read/write pointers; eventData = mem[rdPtr] (combinational read).
//   Latency: scanCodeReady in cycle N completing an event -> eventValid=1 and data visible in cycle N+1 (FIFO previously empty).
//   push & !full -> write. push & full & !pop -> drop and set overflow.
//   push & pop at full -> both occur; count unchanged; no overflow.
//   push & pop at empty -> push only; pop ignored.
//   Pop when empty -> no effect. Pointers wrap modulo FIFO_DEPTH.
// TESTING
// - 1C; then F0 1C -> events 0x01C then 0x21C; eventValid 1 clk after each final byte.
// - E0 75; then E0 F0 75 -> 0x175 then 0x375; F0 E0 75 -> 0x375.
// - 12 -> shiftHeld=1; E0 12 -> event 0x112, shiftHeld stays 1; F0 12 -> shiftHeld=0; E0 14 -> ctrlHeld=1.
// - 8 events with no reads -> fifoCount=8; 9th is dropped and overflow=1; push+pop at full -> count stays 8;
//   overflowClear -> overflow=0; head order preserved.
// - F0, then idle TIMEOUT_CYCLES clk, then 1C -> event 0x01C (make). F0, then rst pulse, then 1C -> 0x01C.
// - E1 14 77 E1 F0 14 F0 77 -> exactly one event 0x1E1; modifiers unchanged.

Source files
------------

// File: rtl/ps2_key_event_controller.sv
// Assembles PS/2 scan-code bytes (E0/F0/E1 prefixes) into key events, tracks modifiers, queues events in a FIFO.
// Latency: the byte that completes an event is visible at the FIFO head one clk later.
// Backpressure: none toward the receiver; a full FIFO drops the event and sets sticky overflow.
module ps2_key_event_controller #(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    scanCode,
    input  logic                          scanCodeReady,
    output logic [9:0]                    eventData,
    output logic                          eventValid,
    input  logic                          eventRead,
    output logic [$clog2(FIFO_DEPTH):0]   fifoCount,
    output logic                          shiftHeld,
    output logic                          ctrlHeld,
    output logic                          altHeld,
    output logic                          overflow,
    input  logic                          overflowClear
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0] B_E0 = 8'hE0;
    localparam logic [7:0] B_F0 = 8'hF0;
    localparam logic [7:0] B_E1 = 8'hE1;

    typedef enum logic [2:0] {IDLE, EXT, BRK, EXTBRK, SKIP} state_t;

    state_t          state;
    logic [2:0]      skip_cnt;
    logic [TW-1:0]   tmo_cnt;
    logic            emit_vld;
    logic [9:0]      emit_dat;
    logic            is_prefix;

    logic [9:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic            full;
    logic            pop;
    logic            push_ok;
    logic            drop;

    logic lshift, rshift, lctrl, rctrl, lalt, ralt;

    assign is_prefix = (scanCode == B_E0) || (scanCode == B_F0);

    always_comb begin
        emit_vld = 1'b0;
        emit_dat = {2'b00, scanCode};
        if (scanCodeReady) begin
            case (state)
                IDLE: begin
                    emit_vld = !is_prefix && (scanCode != B_E1);
                    emit_dat = {2'b00, scanCode};
                end
                EXT: begin
                    emit_vld = !is_prefix;
                    emit_dat = {2'b01, scanCode};
                end
                BRK: begin
                    emit_vld = !is_prefix;
                    emit_dat = {2'b10, scanCode};
                end
                EXTBRK: begin
                    emit_vld = !is_prefix;
                    emit_dat = {2'b11, scanCode};
                end
                SKIP: begin
                    emit_vld = (skip_cnt == 3'd1);
                    emit_dat = {2'b01, B_E1};
                end
                default: emit_vld = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            skip_cnt <= '0;
            tmo_cnt  <= '0;
        end else if (scanCodeReady) begin
            tmo_cnt <= '0;
            case (state)
                IDLE: begin
                    if (scanCode == B_E0)      state <= EXT;
                    else if (scanCode == B_F0) state <= BRK;
                    else if (scanCode == B_E1) begin
                        state    <= SKIP;
                        skip_cnt <= 3'd7;
                    end
                end
                EXT:    if (scanCode == B_F0) state <= EXTBRK;
                        else if (scanCode != B_E0) state <= IDLE;
                BRK:    if (scanCode == B_E0) state <= EXTBRK;
                        else if (scanCode != B_F0) state <= IDLE;
                EXTBRK: if (!is_prefix) state <= IDLE;
                SKIP: begin
                    skip_cnt <= skip_cnt - 3'd1;
                    if (skip_cnt == 3'd1) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end else if (state != IDLE) begin
            // A stalled prefix is abandoned so a lost byte cannot corrupt later keys
            if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                state   <= IDLE;
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
        end else begin
            tmo_cnt <= '0;
        end
    end

    // Left and right keys tracked separately so releasing one side keeps the other held
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            {lshift, rshift, lctrl, rctrl, lalt, ralt} <= '0;
        end else if (emit_vld) begin
            case (emit_dat[8:0])
                9'h012:  lshift <= !emit_dat[9];
                9'h059:  rshift <= !emit_dat[9];
                9'h014:  lctrl  <= !emit_dat[9];
                9'h114:  rctrl  <= !emit_dat[9];
                9'h011:  lalt   <= !emit_dat[9];
                9'h111:  ralt   <= !emit_dat[9];
                default: ;
            endcase
        end
    end

    assign shiftHeld = lshift | rshift;
    assign ctrlHeld  = lctrl | rctrl;
    assign altHeld   = lalt | ralt;

    assign full    = (count == (AW+1)'(FIFO_DEPTH));
    assign pop     = eventRead && (count != '0);
    assign push_ok = emit_vld && (!full || pop);
    assign drop    = emit_vld && full && !pop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else if (push_ok) begin
            mem[wr_ptr] <= emit_dat;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop)      count <= count + 1'b1;
            else if (!push_ok && pop) count <= count - 1'b1;
            overflow <= drop || (overflow && !overflowClear);
        end
    end

    assign eventData  = mem[rd_ptr];
    assign eventValid = (count != '0);
    assign fifoCount  = count;
endmodule
